sr_imem_loader: RTL and testbench

Boot loader and instruction memory for the single-cycle core. It receives a framed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and writes them into an internal instruction RAM. It serves the core's combinational instruction fetch port and holds the core in reset until a frame has loaded and its checksum has passed. It is the writer side of the instruction memory that the core only reads.

---
 rtl/sr_imem_loader_pkg.sv | 21 ++
 rtl/sr_imem_ram.sv | 24 ++
 rtl/sr_imem_loader.sv | 165 ++++++++++++++++
 tb/tb_sr_imem_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_imem_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and frame sync byte.
package sr_imem_loader_pkg;

  typedef enum logic [2:0] {
    LdrIdle  = 3'd0,
    LdrCntLo = 3'd1,
    LdrCntHi = 3'd2,
    LdrData  = 3'd3,
    LdrCsum  = 3'd4,
    LdrRun   = 3'd5,
    LdrError = 3'd6
  } ldr_state_e;

  localparam logic [7:0] LdrSync = 8'hA5;

  // States in which a frame is being received.
  function automatic logic is_loading(ldr_state_e s);
    return (s == LdrCntLo) || (s == LdrCntHi) || (s == LdrData) || (s == LdrCsum);
  endfunction

endpackage

// File: rtl/sr_imem_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port.
module sr_imem_ram #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [31:0]           wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [31:0]           rd
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // A same-cycle write is only visible after the edge, so reads see the old word.
  assign rd = mem[ra];

endmodule

// File: rtl/sr_imem_loader.sv
// Boot loader: parses A5/count/payload/checksum frames into the instruction RAM and holds
// the core in reset until a frame with a good checksum has been loaded.
module sr_imem_loader
  import sr_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter bit          BOOT_HOLD  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic        cpuRst_n,
  output logic        loading,
  output logic        loadErr
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  ldr_state_e            state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  rx_ready_q;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  loading_q, loading_d;
  logic                  load_err_q, load_err_d;

  logic                  accept;
  logic                  sync_seen;
  logic                  ram_we;
  logic [31:0]           ram_wd;
  logic [15:0]           count;
  logic [15:0]           count_m1;
  logic                  count_bad;
  logic                  unused_imaddr;

  assign accept    = rxValid & rx_ready_q;
  assign count     = {rxData, cnt_lo_q};
  assign count_m1  = count - 16'd1;
  assign count_bad = (count == 16'd0) || (32'(count) > Depth);
  assign ram_wd    = {rxData, word_q};

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    last_d      = last_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    ram_we      = 1'b0;
    sync_seen   = 1'b0;
    if (accept) begin
      unique case (state_q)
        LdrIdle, LdrRun, LdrError: begin
          if (rxData == LdrSync) begin
            state_d   = LdrCntLo;
            sync_seen = 1'b1;
          end
        end
        LdrCntLo: begin
          cnt_lo_d = rxData;
          state_d  = LdrCntHi;
        end
        LdrCntHi: begin
          if (count_bad) begin
            state_d = LdrError;
          end else begin
            last_d      = count_m1[ADDR_WIDTH-1:0];
            word_addr_d = '0;
            byte_idx_d  = 2'd0;
            csum_d      = 8'd0;
            state_d     = LdrData;
          end
        end
        LdrData: begin
          // Bytes arrive LSB first, so shift right and complete the word with byte 3.
          word_d     = {rxData, word_q[23:8]};
          csum_d     = csum_q + rxData;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            ram_we      = rst_n;
            word_addr_d = word_addr_q + ADDR_WIDTH'(1);
            if (word_addr_q == last_q) begin
              state_d = LdrCsum;
            end
          end
        end
        LdrCsum: begin
          state_d = (rxData == csum_q) ? LdrRun : LdrError;
        end
        default: begin
          state_d = LdrIdle;
        end
      endcase
    end
  end

  always_comb begin
    cpu_rst_n_d = (state_d == LdrRun) || ((state_d == LdrIdle) && !BOOT_HOLD);
    loading_d   = is_loading(state_d);
    load_err_d  = load_err_q;
    if (sync_seen) begin
      load_err_d = 1'b0;
    end
    if ((state_d == LdrError) && (state_q != LdrError)) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LdrIdle;
      cnt_lo_q    <= 8'd0;
      last_q      <= '0;
      word_addr_q <= '0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      csum_q      <= 8'd0;
      rx_ready_q  <= 1'b0;
      cpu_rst_n_q <= !BOOT_HOLD;
      loading_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      last_q      <= last_d;
      word_addr_q <= word_addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      rx_ready_q  <= 1'b1;
      cpu_rst_n_q <= cpu_rst_n_d;
      loading_q   <= loading_d;
      load_err_q  <= load_err_d;
    end
  end

  sr_imem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk(clk),
    .we (ram_we),
    .wa (word_addr_q),
    .wd (ram_wd),
    .ra (imAddr[ADDR_WIDTH-1:0]),
    .rd (imData)
  );

  // Upper fetch address bits are ignored so the address space wraps.
  assign unused_imaddr = ^imAddr[31:ADDR_WIDTH];

  assign rxReady  = rx_ready_q;
  assign cpuRst_n = cpu_rst_n_q;
  assign loading  = loading_q;
  assign loadErr  = load_err_q;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Randomised frame stimulus checked every cycle against a frame-level model of the loader.
module tb_sr_imem_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        cpuRst_n;
  logic        loading;
  logic        loadErr;

  always #5 clk = ~clk;

  sr_imem_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .imAddr  (imAddr),
    .imData  (imData),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .cpuRst_n(cpuRst_n),
    .loading (loading),
    .loadErr (loadErr)
  );

  int          checks = 0;
  int          failures = 0;
  logic        exp_ready, exp_cpu, exp_loading, exp_err;
  logic [31:0] model_mem [64];
  bit          known [64];
  bit          chk_en = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_addr = 32'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle compare against the model, then pick the next fetch address.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rxReady", 32'(rxReady), 32'(exp_ready));
      chk("cpuRst_n", 32'(cpuRst_n), 32'(exp_cpu));
      chk("loading", 32'(loading), 32'(exp_loading));
      chk("loadErr", 32'(loadErr), 32'(exp_err));
      if (known[imAddr[5:0]]) chk("imData", imData, model_mem[imAddr[5:0]]);
    end
    imAddr = force_en ? force_addr : $urandom;
  end

  task automatic rd_chk(string name, logic [31:0] addr, logic [31:0] exp);
    force_en = 1'b1;
    force_addr = addr;
    @(negedge clk);
    #2;
    chk(name, imData, exp);
    force_en = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    rxValid = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b0; exp_cpu = 1'b0; exp_loading = 1'b0; exp_err = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b1;
  endtask

  task automatic send_byte(logic [7:0] b, int gap_max);
    repeat ($urandom_range(gap_max)) begin
      rxValid = 1'b0;
      rxData = 8'($urandom);
      @(posedge clk); #1;
    end
    rxValid = 1'b1;
    rxData = b;
    @(posedge clk); #1;
    rxValid = 1'b0;
    rxData = 8'($urandom);
  endtask

  task automatic send_junk();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    send_byte(b, 1);
  endtask

  // Sends f[first..last-1]; expectations follow from each byte's position in the frame.
  task automatic send_frame(byte_q_t f, int gap_max, int first, int last);
    int n;
    bit bad;
    logic [7:0] sum;
    n = int'({f[2], f[1]});
    bad = (n == 0) || (n > 64);
    for (int i = first; i < last; i++) begin
      send_byte(f[i], gap_max);
      if (i == 0) begin
        exp_loading = 1'b1; exp_cpu = 1'b0; exp_err = 1'b0;
      end else if (i == 2 && bad) begin
        exp_loading = 1'b0; exp_cpu = 1'b0; exp_err = 1'b1;
        break;
      end else if (i >= 3 && i < 3 + 4 * n) begin
        if ((i - 3) % 4 == 3) begin
          model_mem[(i - 3) / 4] = {f[i], f[i-1], f[i-2], f[i-3]};
          known[(i - 3) / 4] = 1'b1;
        end
      end else if (i == 3 + 4 * n) begin
        sum = 8'd0;
        for (int j = 3; j < 3 + 4 * n; j++) sum = sum + f[j];
        exp_loading = 1'b0;
        exp_cpu = (f[i] == sum);
        exp_err = (f[i] != sum);
      end
    end
  endtask

  function automatic byte_q_t build_frame(word_q_t words, bit corrupt);
    byte_q_t f;
    logic [7:0] sum;
    logic [15:0] n;
    n = 16'(words.size());
    sum = 8'd0;
    f = '{8'hA5, n[7:0], n[15:8]};
    foreach (words[k]) begin
      for (int s = 0; s < 4; s++) begin
        f.push_back(words[k][8*s +: 8]);
        sum = sum + words[k][8*s +: 8];
      end
    end
    f.push_back(corrupt ? sum + 8'd1 : sum);
    return f;
  endfunction

  initial begin
    byte_q_t f_good, f_bad, f_c0, f_c41, f_one, f;
    word_q_t w;
    int n;
    f_good = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    f_bad = f_good;
    f_bad[11] = 8'h88;
    f_c0 = '{8'hA5, 8'h00, 8'h00};
    f_c41 = '{8'hA5, 8'h41, 8'h00};
    f_one = '{8'hA5, 8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h6F};
    foreach (known[k]) known[k] = 1'b0;

    rst_n = 1'b0;
    rxValid = 1'b0;
    rxData = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rxReady", 32'(rxReady), 32'd0);
    chk("reset cpuRst_n", 32'(cpuRst_n), 32'd0);
    chk("reset loading", 32'(loading), 32'd0);
    chk("reset loadErr", 32'(loadErr), 32'd0);
    exp_ready = 1'b0; exp_cpu = 1'b0; exp_loading = 1'b0; exp_err = 1'b0;
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rxReady after reset", 32'(rxReady), 32'd1);
    exp_ready = 1'b1;

    // Good load
    send_junk();
    send_frame(f_good, 0, 0, 11);
    chk("cpu held before csum", 32'(cpuRst_n), 32'd0);
    send_frame(f_good, 0, 11, 12);
    chk("cpu released", 32'(cpuRst_n), 32'd1);
    chk("good loadErr", 32'(loadErr), 32'd0);
    rd_chk("word0", 32'd0, 32'h00500093);
    rd_chk("word1", 32'd1, 32'h00108113);
    rd_chk("wrap 64", 32'd64, 32'h00500093);
    rd_chk("wrap 0x40000001", 32'h40000001, 32'h00108113);

    // Bad checksum, then resend
    send_frame(f_bad, 0, 0, 12);
    chk("bad csum loadErr", 32'(loadErr), 32'd1);
    chk("bad csum cpuRst_n", 32'(cpuRst_n), 32'd0);
    send_frame(f_good, 0, 0, 1);
    chk("err clears on sync", 32'(loadErr), 32'd0);
    send_frame(f_good, 0, 1, 12);
    chk("resend cpuRst_n", 32'(cpuRst_n), 32'd1);

    // Illegal counts
    send_frame(f_c0, 0, 0, 3);
    chk("count0 loadErr", 32'(loadErr), 32'd1);
    chk("count0 loading", 32'(loading), 32'd0);
    send_frame(f_c41, 0, 0, 3);
    chk("count65 loadErr", 32'(loadErr), 32'd1);
    rd_chk("count65 word0 kept", 32'd0, 32'h00500093);
    rd_chk("count65 word1 kept", 32'd1, 32'h00108113);

    // Sync while running puts the core back in reset
    send_frame(f_good, 0, 0, 12);
    send_frame(f_one, 0, 0, 1);
    chk("run sync cpuRst_n", 32'(cpuRst_n), 32'd0);
    chk("run sync loading", 32'(loading), 32'd1);
    send_frame(f_one, 0, 1, 8);
    rd_chk("one-word addr0", 32'd0, 32'h0000006F);
    rd_chk("one-word addr1", 32'd1, 32'h00108113);
    chk("one-word cpuRst_n", 32'(cpuRst_n), 32'd1);

    // Gapped load
    send_frame(f_good, 3, 0, 12);
    rd_chk("gap word0", 32'd0, 32'h00500093);
    rd_chk("gap word1", 32'd1, 32'h00108113);
    chk("gap cpuRst_n", 32'(cpuRst_n), 32'd1);

    // Reset after 5 payload bytes: word 0 lands, word 1 must not change
    w = '{32'h11111111, 32'h22222222};
    send_frame(build_frame(w, 1'b0), 1, 0, 12);
    send_frame(f_good, 0, 0, 8);
    do_reset();
    chk("abort loading", 32'(loading), 32'd0);
    chk("abort cpuRst_n", 32'(cpuRst_n), 32'd0);
    rd_chk("abort word0", 32'd0, 32'h00500093);
    rd_chk("abort word1", 32'd1, 32'h22222222);

    // Random frames, with corrupted checksums, aborts and a full-depth load
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(1) == 1) send_junk();
      n = (r == 9) ? 64 : int'($urandom_range(8, 1));
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      f = build_frame(w, $urandom_range(3) == 0);
      if (r != 9 && $urandom_range(4) == 0) begin
        send_frame(f, 2, 0, int'($urandom_range(f.size() - 1, 3)));
        do_reset();
      end else begin
        send_frame(f, 2, 0, f.size());
      end
    end
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
